// File: rtl/wb_status_regs_pkg.sv
// Shared definitions for the read-only Wishbone status register block:
// address map constants and the responder FSM encoding.
package wb_status_regs_pkg;

  localparam int ADR_STICKY      = 0;
  localparam int ADR_STATUS_BASE = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage : wb_status_regs_pkg

// File: rtl/sticky_event_reg.sv
// Sticky event capture: bits set by event pulses stay set until cleared.
// Set has priority over hold; a clear drops everything, including same-cycle sets.
module sticky_event_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] set,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  // Same-cycle sets during a clear are not kept here; the parent reports
  // them in the read data taken on that same edge, so nothing is lost.
  assign q_next = clr ? '0 : (q | set);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

endmodule : sticky_event_reg

// File: rtl/wb_status_regs.sv
// Read-only Wishbone classic responder for hardware-owned status: a
// read-to-clear sticky event register plus NUM_STATUS live status words.
module wb_status_regs
  import wb_status_regs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STATUS = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wb_cyc_i,
  input  logic                             wb_stb_i,
  input  logic                             wb_we_i,
  input  logic [ADDR_WIDTH-1:0]            wb_adr_i,
  output logic [DATA_WIDTH-1:0]            wb_dat_o,
  output logic                             wb_ack_o,
  output logic                             wb_err_o,
  input  logic [DATA_WIDTH-1:0]            event_i,
  input  logic [NUM_STATUS*DATA_WIDTH-1:0] status_i,
  output logic                             irq_o
);

  state_t                state, state_next;
  logic                  req, accept;
  logic                  hit_sticky, hit_status, bad_access;
  logic                  sticky_clr;
  logic [DATA_WIDTH-1:0] sticky_q, sticky_next;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  ack_next, err_next;

  assign req    = wb_cyc_i & wb_stb_i;
  assign accept = (state == ST_IDLE) & req;

  assign hit_sticky = (wb_adr_i == ADDR_WIDTH'(ADR_STICKY));
  assign hit_status = (wb_adr_i >= ADDR_WIDTH'(ADR_STATUS_BASE)) &&
                      (wb_adr_i <= ADDR_WIDTH'(ADR_STATUS_BASE + NUM_STATUS - 1));
  assign bad_access = wb_we_i | ~(hit_sticky | hit_status);

  // Only an accepted, well-formed read of STICKY clears it; errors leave it intact.
  assign sticky_clr = accept & ~bad_access & hit_sticky;

  sticky_event_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_sticky (
    .clk    (clk),
    .rst    (rst),
    .set    (event_i),
    .clr    (sticky_clr),
    .q      (sticky_q),
    .q_next (sticky_next)
  );

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    status_word = '0;
    for (int k = 0; k < NUM_STATUS; k++) begin
      if (wb_adr_i == ADDR_WIDTH'(ADR_STATUS_BASE + k))
        status_word = status_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    rd_data = '0;
    if (!bad_access) begin
      if (hit_sticky) rd_data = sticky_q | event_i;
      else            rd_data = status_word;
    end
  end

  always_comb begin
    state_next = state;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_RESP;
          ack_next   = ~bad_access;
          err_next   = bad_access;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= 1'b0;
    end else begin
      state    <= state_next;
      wb_ack_o <= ack_next;
      wb_err_o <= err_next;
      irq_o    <= |sticky_next;
      if (accept) wb_dat_o <= rd_data;
    end
  end

endmodule : wb_status_regs
